// File: rtl/permute_pkg.sv
// Shared types and constants for the odd-pipe permute unit.
package permute_pkg;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_SHLQBI  = 3'd1,
    OP_SHLQBY  = 3'd2,
    OP_ROTQBY  = 3'd3,
    OP_ROTQBI  = 3'd4,
    OP_ROTQMBY = 3'd5,
    OP_SHUFB   = 3'd6
  } op_t;

  // Amount field in src_reg_b, big-endian bit numbering (bit 0 = MSB).
  localparam int AMT_BE_FIRST = 27;
  localparam int AMT_BE_LAST  = 31;
  localparam int AMT_W        = AMT_BE_LAST - AMT_BE_FIRST + 1;
  localparam int BC_W         = 3;

  localparam logic [1:0] SHUFB_ZERO_CODE = 2'b10;
  localparam logic [2:0] SHUFB_ONES_CODE = 3'b110;
  localparam logic [2:0] SHUFB_MSB_CODE  = 3'b111;
  localparam logic [7:0] SHUFB_ONES_BYTE = 8'hFF;
  localparam logic [7:0] SHUFB_MSB_BYTE  = 8'h80;

endpackage

// File: rtl/permute_core.sv
// Combinational quadword permute/shift/rotate datapath; byte 0 is the most
// significant byte of each operand.
module permute_core
  import permute_pkg::*;
#(
  parameter int DATA_BYTES = 16
) (
  input  op_t                     op_i,
  input  logic [8*DATA_BYTES-1:0] a_i,
  input  logic [8*DATA_BYTES-1:0] b_i,
  input  logic [8*DATA_BYTES-1:0] c_i,
  input  logic [AMT_W-1:0]        amt_i,
  output logic [8*DATA_BYTES-1:0] result_o,
  output logic                    illegal_o
);

  localparam int W     = 8 * DATA_BYTES;
  localparam int IDX_W = $clog2(DATA_BYTES);
  localparam int SEL_W = $clog2(2 * DATA_BYTES);
  localparam logic [AMT_W-1:0] DB_AMT = AMT_W'(DATA_BYTES);

  logic [BC_W-1:0]  bc;
  logic [IDX_W-1:0] rot_by;
  logic [2*W-1:0]   dbl_sh;
  logic [2*W-1:0]   ab_sh;
  logic [7:0]       cb;
  logic [SEL_W-1:0] sel;

  assign bc     = amt_i[BC_W-1:0];
  assign rot_by = amt_i[IDX_W-1:0];

  always_comb begin
    result_o  = '0;
    illegal_o = 1'b0;
    dbl_sh    = '0;
    ab_sh     = '0;
    cb        = '0;
    sel       = '0;
    case (op_i)
      OP_NOP: ;
      OP_SHLQBI: result_o = a_i << bc;
      OP_SHLQBY: result_o = (amt_i >= DB_AMT) ? '0 : (a_i << {amt_i, 3'b000});
      // Rotates shift a doubled operand and keep the upper half.
      OP_ROTQBY: begin
        dbl_sh   = {a_i, a_i} << {rot_by, 3'b000};
        result_o = dbl_sh[2*W-1 -: W];
      end
      OP_ROTQBI: begin
        dbl_sh   = {a_i, a_i} << bc;
        result_o = dbl_sh[2*W-1 -: W];
      end
      OP_ROTQMBY: result_o = (amt_i >= DB_AMT) ? '0 : (a_i >> {amt_i, 3'b000});
      OP_SHUFB: begin
        for (int i = 0; i < DATA_BYTES; i++) begin
          cb    = c_i[W-1-8*i -: 8];
          sel   = cb[SEL_W-1:0];
          ab_sh = {a_i, b_i} << {sel, 3'b000};
          if (cb[7:6] == SHUFB_ZERO_CODE)      result_o[W-1-8*i -: 8] = 8'h00;
          else if (cb[7:5] == SHUFB_ONES_CODE) result_o[W-1-8*i -: 8] = SHUFB_ONES_BYTE;
          else if (cb[7:5] == SHUFB_MSB_CODE)  result_o[W-1-8*i -: 8] = SHUFB_MSB_BYTE;
          else                                 result_o[W-1-8*i -: 8] = ab_sh[2*W-1 -: 8];
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/permute_pipe.sv
// Pipelined permute unit: stage 0 captures the core result, later stages
// only stage it toward writeback and expose forwarding taps.
module permute_pipe
  import permute_pkg::*;
#(
  parameter int DATA_BYTES = 16,
  parameter int LATENCY    = 4,
  parameter int REG_ADDR_W = 7
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  op_t                               op_i,
  input  logic                              use_imm_i,
  input  logic [17:0]                       imm_value_i,
  input  logic [8*DATA_BYTES-1:0]           src_reg_a_i,
  input  logic [8*DATA_BYTES-1:0]           src_reg_b_i,
  input  logic [8*DATA_BYTES-1:0]           src_reg_c_i,
  input  logic [REG_ADDR_W-1:0]             dest_reg_addr_i,
  input  logic                              enable_reg_write_i,
  input  logic                              branch_is_taken_i,
  input  logic                              stall_i,
  output logic [8*DATA_BYTES-1:0]           wb_data_o,
  output logic [REG_ADDR_W-1:0]             wb_reg_addr_o,
  output logic                              wb_enable_reg_write_o,
  output logic [LATENCY-1:0]                fwd_valid_o,
  output logic [LATENCY*REG_ADDR_W-1:0]     fwd_addr_o,
  output logic [LATENCY*8*DATA_BYTES-1:0]   fwd_data_o,
  output logic                              illegal_op_o
);

  localparam int W = 8 * DATA_BYTES;

  logic [LATENCY-1:0]                 valid_q, valid_d;
  logic [LATENCY-1:0][REG_ADDR_W-1:0] addr_q, addr_d;
  logic [LATENCY-1:0][W-1:0]          data_q, data_d;
  logic                               illegal_q, illegal_d;

  logic [AMT_W-1:0]      amt;
  logic [W-1:0]          core_result;
  logic                  core_illegal;
  logic                  kill;
  logic                  s0_valid;
  logic [REG_ADDR_W-1:0] s0_addr;
  logic [W-1:0]          s0_data;
  logic                  unused_imm;

  assign amt = use_imm_i ? imm_value_i[AMT_W-1:0]
                         : src_reg_b_i[W-1-AMT_BE_LAST +: AMT_W];
  assign unused_imm = ^imm_value_i[17:AMT_W];

  permute_core #(.DATA_BYTES(DATA_BYTES)) u_core (
    .op_i      (op_i),
    .a_i       (src_reg_a_i),
    .b_i       (src_reg_b_i),
    .c_i       (src_reg_c_i),
    .amt_i     (amt),
    .result_o  (core_result),
    .illegal_o (core_illegal)
  );

  // Killed, NOP and undefined ops all enter as a clean bubble.
  assign kill     = branch_is_taken_i | core_illegal | (op_i == OP_NOP);
  assign s0_valid = ~kill & enable_reg_write_i;
  assign s0_addr  = kill ? '0 : dest_reg_addr_i;
  assign s0_data  = kill ? '0 : core_result;

  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    data_d    = data_q;
    illegal_d = 1'b0;
    if (!stall_i) begin
      valid_d   = {valid_q[LATENCY-2:0], s0_valid};
      addr_d    = {addr_q[LATENCY-2:0], s0_addr};
      data_d    = {data_q[LATENCY-2:0], s0_data};
      illegal_d = core_illegal & ~branch_is_taken_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      illegal_q <= illegal_d;
    end
  end

  assign wb_data_o             = data_q[LATENCY-1];
  assign wb_reg_addr_o         = addr_q[LATENCY-1];
  assign wb_enable_reg_write_o = valid_q[LATENCY-1];
  assign fwd_valid_o           = valid_q;
  assign fwd_addr_o            = addr_q;
  assign fwd_data_o            = data_q;
  assign illegal_op_o          = illegal_q & ~stall_i;

endmodule

// File: tb/tb_permute_pipe.sv
// Directed-vector bench for permute_pipe with DATA_BYTES=16, LATENCY=4.
module tb_permute_pipe;
  import permute_pkg::*;

  localparam int DB  = 16;
  localparam int LAT = 4;
  localparam int AW  = 7;
  localparam int W   = 8 * DB;

  localparam logic [W-1:0] A0   = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [W-1:0] ROT3 = 128'h030405060708090A0B0C0D0E0F000102;
  localparam logic [W-1:0] ROT1 = 128'h0102030405060708090A0B0C0D0E0F00;
  localparam logic [W-1:0] SHL1 = 128'h00020406080A0C0E10121416181A1C1E;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  op_t op;
  logic use_imm, en, br, stall;
  logic [17:0] imm;
  logic [W-1:0] a, b, c;
  logic [AW-1:0] dest;
  logic [W-1:0] wb_data;
  logic [AW-1:0] wb_addr;
  logic wb_en, illegal;
  logic [LAT-1:0] fwd_valid;
  logic [LAT*AW-1:0] fwd_addr;
  logic [LAT*W-1:0] fwd_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  permute_pipe #(.DATA_BYTES(DB), .LATENCY(LAT), .REG_ADDR_W(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .use_imm_i(use_imm),
    .imm_value_i(imm), .src_reg_a_i(a), .src_reg_b_i(b), .src_reg_c_i(c),
    .dest_reg_addr_i(dest), .enable_reg_write_i(en),
    .branch_is_taken_i(br), .stall_i(stall),
    .wb_data_o(wb_data), .wb_reg_addr_o(wb_addr),
    .wb_enable_reg_write_o(wb_en), .fwd_valid_o(fwd_valid),
    .fwd_addr_o(fwd_addr), .fwd_data_o(fwd_data), .illegal_op_o(illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input op_t o, input logic ui, input logic [17:0] im,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] cv, input logic [AW-1:0] d,
                       input logic e, input logic bt);
    op = o; use_imm = ui; imm = im; a = av; b = bv; c = cv;
    dest = d; en = e; br = bt; stall = 1'b0;
  endtask

  task automatic idle();
    drive(OP_NOP, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  // Issue one op, drain it to writeback, and return the writeback view.
  task automatic run_op(input op_t o, input logic ui, input logic [17:0] im,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] cv, input logic [AW-1:0] d,
                        output logic [W-1:0] rd, output logic [AW-1:0] ra,
                        output logic re);
    drive(o, ui, im, av, bv, cv, d, 1'b1, 1'b0);
    tick();
    idle();
    repeat (LAT - 1) tick();
    rd = wb_data; ra = wb_addr; re = wb_en;
  endtask

  task automatic test_reset();
    drive(OP_ROTQBY, 1'b1, 18'd3, A0, '0, '0, 7'd5, 1'b1, 1'b0);
    #3;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b expected 0", wb_en); end
    checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
    tick();
    checks++; if (fwd_valid !== '0) begin errors++; $display("FAIL reset_fwd_valid: got %b expected 0", fwd_valid); end
    checks++; if (fwd_addr !== '0) begin errors++; $display("FAIL reset_fwd_addr: got %h expected 0", fwd_addr); end
    checks++; if (fwd_data !== '0) begin errors++; $display("FAIL reset_fwd_data: got %h expected 0", fwd_data); end
    checks++; if (wb_addr !== '0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_addr_illegal: got %h/%b expected 0/0", wb_addr, illegal); end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_pipe();
    drive(OP_ROTQBY, 1'b1, 18'd3, A0, '0, '0, 7'd5, 1'b1, 1'b0);
    tick();
    checks++; if (fwd_valid !== 4'b0001) begin errors++; $display("FAIL pipe_s0_valid: got %b expected 0001", fwd_valid); end
    checks++; if (fwd_addr[AW-1:0] !== 7'd5) begin errors++; $display("FAIL pipe_s0_addr: got %0d expected 5", fwd_addr[AW-1:0]); end
    checks++; if (fwd_data[W-1:0] !== ROT3) begin errors++; $display("FAIL pipe_s0_data: got %h expected %h", fwd_data[W-1:0], ROT3); end
    idle();
    for (int k = 0; k < LAT - 2; k++) begin
      tick();
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL pipe_early_wb: cycle %0d got %b expected 0", k, wb_en); end
    end
    tick();
    checks++; if (wb_data !== ROT3) begin errors++; $display("FAIL pipe_wb_data: got %h expected %h", wb_data, ROT3); end
    checks++; if (wb_addr !== 7'd5 || wb_en !== 1'b1) begin errors++; $display("FAIL pipe_wb_ctl: got %0d/%b expected 5/1", wb_addr, wb_en); end
  endtask

  task automatic test_shift();
    logic [W-1:0] rd; logic [AW-1:0] ra; logic re;
    run_op(OP_SHLQBY, 1'b1, 18'd16, A0, '0, '0, 7'd11, rd, ra, re);
    checks++; if (rd !== '0 || ra !== 7'd11 || re !== 1'b1) begin errors++; $display("FAIL shlqby_16: got %h/%0d/%b expected 0/11/1", rd, ra, re); end
    run_op(OP_SHLQBY, 1'b1, 18'd15, A0, '0, '0, 7'd12, rd, ra, re);
    checks++; if (rd !== 128'h0F000000000000000000000000000000) begin errors++; $display("FAIL shlqby_15: got %h expected 0F00..00", rd); end
    run_op(OP_SHLQBI, 1'b1, 18'h0000B, 128'h1, '0, '0, 7'd13, rd, ra, re);
    checks++; if (rd !== 128'h8) begin errors++; $display("FAIL shlqbi_bc3: got %h expected 8", rd); end
    run_op(OP_ROTQMBY, 1'b1, 18'd1, A0, '0, '0, 7'd14, rd, ra, re);
    checks++; if (rd !== 128'h00000102030405060708090A0B0C0D0E) begin errors++; $display("FAIL rotqmby_1: got %h expected 00000102..0D0E", rd); end
    run_op(OP_ROTQBY, 1'b1, 18'd19, A0, '0, '0, 7'd15, rd, ra, re);
    checks++; if (rd !== ROT3) begin errors++; $display("FAIL rotqby_wrap19: got %h expected %h", rd, ROT3); end
    // Amount from the preferred-slot word of src_reg_b, imm ignored.
    run_op(OP_ROTQBI, 1'b0, 18'd1, 128'h8000000000000000000000000000000F,
           128'h00000004000000000000000000000000, '0, 7'd16, rd, ra, re);
    checks++; if (rd !== 128'hF8) begin errors++; $display("FAIL rotqbi_regamt: got %h expected F8", rd); end
  endtask

  task automatic test_shufb();
    logic [W-1:0] rd; logic [AW-1:0] ra; logic re;
    logic [W-1:0] af, bf;
    af = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    bf = 128'h101112131415161718191A1B1C1D1E1F;
    run_op(OP_SHUFB, 1'b1, '0, af, bf, 128'h80C0E01F000000000000000000000000, 7'd20, rd, ra, re);
    checks++; if (rd !== 128'h00FF801FF0F0F0F0F0F0F0F0F0F0F0F0) begin errors++; $display("FAIL shufb_codes: got %h expected 00FF801FF0F0..F0", rd); end
    run_op(OP_SHUFB, 1'b1, '0, af, bf, 128'h10053FA50E0E0E0E0E0E0E0E0E0E0E0E, 7'd21, rd, ra, re);
    checks++; if (rd !== 128'h10F51F00FEFEFEFEFEFEFEFEFEFEFEFE) begin errors++; $display("FAIL shufb_select: got %h expected 10F51F00FEFE..FE", rd); end
  endtask

  task automatic test_back_to_back_flush();
    drive(OP_ROTQBY, 1'b1, 18'd1, A0, '0, '0, 7'd1, 1'b1, 1'b0); tick();
    drive(OP_SHLQBI, 1'b1, 18'd1, A0, '0, '0, 7'd2, 1'b1, 1'b1); tick();
    drive(OP_ROTQMBY, 1'b1, 18'd2, A0, '0, '0, 7'd3, 1'b1, 1'b0); tick();
    idle(); tick();
    checks++; if (wb_en !== 1'b1 || wb_addr !== 7'd1 || wb_data !== ROT1) begin errors++; $display("FAIL flush_op1: got %b/%0d/%h expected 1/1/%h", wb_en, wb_addr, wb_data, ROT1); end
    tick();
    checks++; if (wb_en !== 1'b0 || wb_addr !== 7'd0 || wb_data !== '0) begin errors++; $display("FAIL flush_killed: got %b/%0d/%h expected 0/0/0", wb_en, wb_addr, wb_data); end
    tick();
    checks++; if (wb_en !== 1'b1 || wb_addr !== 7'd3 || wb_data !== 128'h0000000102030405060708090A0B0C0D) begin errors++; $display("FAIL flush_op3: got %b/%0d/%h expected 1/3/00000001..0D", wb_en, wb_addr, wb_data); end
  endtask

  task automatic test_stall();
    drive(OP_ROTQBY, 1'b1, 18'd3, A0, '0, '0, 7'd7, 1'b1, 1'b0); tick();
    drive(OP_SHLQBI, 1'b1, 18'd1, A0, '0, '0, 7'd8, 1'b1, 1'b0); tick();
    for (int s = 0; s < 2; s++) begin
      if (s == 0) drive(op_t'(3'd7), 1'b1, '0, A0, '0, '0, 7'd9, 1'b1, 1'b0);
      else        drive(OP_ROTQBY, 1'b1, 18'd5, A0, '0, '0, 7'd9, 1'b1, 1'b1);
      stall = 1'b1;
      tick();
      checks++; if (fwd_valid !== 4'b0011 || fwd_addr[2*AW-1:0] !== {7'd7, 7'd8}) begin errors++; $display("FAIL stall_ctl_%0d: got %b/%h expected 0011/%h", s, fwd_valid, fwd_addr[2*AW-1:0], {7'd7, 7'd8}); end
      checks++; if (fwd_data[2*W-1:0] !== {ROT3, SHL1}) begin errors++; $display("FAIL stall_data_%0d: got %h expected %h", s, fwd_data[2*W-1:0], {ROT3, SHL1}); end
      checks++; if (illegal !== 1'b0 || wb_en !== 1'b0) begin errors++; $display("FAIL stall_quiet_%0d: got %b/%b expected 0/0", s, illegal, wb_en); end
    end
    idle(); tick();
    checks++; if (fwd_valid !== 4'b0110) begin errors++; $display("FAIL stall_resume: got %b expected 0110", fwd_valid); end
    tick();
    checks++; if (wb_en !== 1'b1 || wb_addr !== 7'd7 || wb_data !== ROT3) begin errors++; $display("FAIL stall_wb1: got %b/%0d/%h expected 1/7/%h", wb_en, wb_addr, wb_data, ROT3); end
    tick();
    checks++; if (wb_en !== 1'b1 || wb_addr !== 7'd8 || wb_data !== SHL1) begin errors++; $display("FAIL stall_wb2: got %b/%0d/%h expected 1/8/%h", wb_en, wb_addr, wb_data, SHL1); end
  endtask

  task automatic test_illegal();
    drive(op_t'(3'd7), 1'b1, 18'd3, A0, '0, '0, 7'd9, 1'b1, 1'b0); tick();
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL illegal_pulse: got %b expected 1", illegal); end
    checks++; if (fwd_valid[0] !== 1'b0 || fwd_addr[AW-1:0] !== '0 || fwd_data[W-1:0] !== '0) begin errors++; $display("FAIL illegal_bubble: got %b/%0d/%h expected 0/0/0", fwd_valid[0], fwd_addr[AW-1:0], fwd_data[W-1:0]); end
    drive(OP_NOP, 1'b1, 18'd3, A0, '0, '0, 7'd4, 1'b1, 1'b0); tick();
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_one_cycle: got %b expected 0", illegal); end
    checks++; if (fwd_valid[0] !== 1'b0 || fwd_addr[AW-1:0] !== '0) begin errors++; $display("FAIL nop_bubble: got %b/%0d expected 0/0", fwd_valid[0], fwd_addr[AW-1:0]); end
    drive(OP_ROTQBY, 1'b1, 18'd3, A0, '0, '0, 7'd6, 1'b0, 1'b0); tick();
    checks++; if (fwd_valid[0] !== 1'b0 || fwd_addr[AW-1:0] !== 7'd6 || fwd_data[W-1:0] !== ROT3) begin errors++; $display("FAIL noenable_carry: got %b/%0d/%h expected 0/6/%h", fwd_valid[0], fwd_addr[AW-1:0], fwd_data[W-1:0], ROT3); end
    idle(); repeat (LAT) tick();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < LAT; k++) begin
      drive(OP_ROTQBY, 1'b1, '0, A0, '0, '0, AW'(10 + k), 1'b1, 1'b0);
      tick();
    end
    checks++; if (wb_en !== 1'b1 || wb_addr !== 7'd10 || fwd_valid !== 4'b1111) begin errors++; $display("FAIL areset_full: got %b/%0d/%b expected 1/10/1111", wb_en, wb_addr, fwd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wb_en !== 1'b0 || wb_data !== '0 || wb_addr !== '0) begin errors++; $display("FAIL areset_wb: got %b/%h/%0d expected 0/0/0", wb_en, wb_data, wb_addr); end
    checks++; if (fwd_valid !== '0 || fwd_addr !== '0 || fwd_data !== '0) begin errors++; $display("FAIL areset_fwd: got %b/%h expected 0/0", fwd_valid, fwd_addr); end
    tick();
    idle();
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 1; k++) begin
      tick();
      checks++; if (wb_en !== 1'b0 || fwd_valid !== '0) begin errors++; $display("FAIL areset_stale_%0d: got %b/%b expected 0/0", k, wb_en, fwd_valid); end
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_pipe();
    test_shift();
    test_shufb();
    test_back_to_back_flush();
    test_stall();
    test_illegal();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/permute_pipe.md
# permute_pipe

Parametrised, pipelined permute/shift/rotate unit for the odd pipe of the SPU. It accepts one decoded quadword operation per cycle, computes the byte/bit permutation in stage 0, and carries the result through a configurable-depth staging pipe with per-stage forwarding taps. Results write back at the last stage. Compared with the fixed-latency permute path, this unit adds shuffle-bytes, rotate-by-bits and shift-right-bytes, plus a pipeline stall and an illegal-op flag.

## Interface
- DATA_BYTES, 16, vector width in bytes; power of 2, 4..16.
- LATENCY, 4, issue-to-writeback cycles; 2..8.
- REG_ADDR_W, 7, register address width.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- op  in  op_t  decoded operation (package enum).
- use_imm  in  1  amount from imm_value instead of src_reg_b.
- imm_value  in  18  immediate; bits [4:0] are the amount field.
- src_reg_a, src_reg_b, src_reg_c  in  8*DATA_BYTES each  operands (bit 0 = MSB, byte 0 = most significant).
- dest_reg_addr  in  REG_ADDR_W  destination register.
- enable_reg_write  in  1  instruction writes the register file.
- branch_is_taken  in  1  kill the instruction presented this cycle.
- stall  in  1  freeze all stages; input ignored.
- wb_data  out  8*DATA_BYTES  result at stage LATENCY-1.
- wb_reg_addr  out  REG_ADDR_W  destination for wb_data.
- wb_enable_reg_write  out  1  write strobe.
- fwd_valid  out  LATENCY  per-stage write-enable tap.
- fwd_addr  out  LATENCY*REG_ADDR_W  per-stage address tap.
- fwd_data  out  LATENCY*8*DATA_BYTES  per-stage data tap.
- illegal_op  out  1  one-cycle pulse: undefined op accepted.

## Operation
- Amount field `amt` is imm_value[4:0] if use_imm, else src_reg_b bits [27:31] (preferred-slot word).
- Bit count `bc` = amt[2:0]. Byte count `by` = amt.
- SHLQBI: a << bc, zero fill.
- SHLQBY: a shifted left by `by` bytes. If by >= DATA_BYTES, the result is 0.
- ROTQBY: byte i = a byte (i+by) mod DATA_BYTES.
- ROTQBI: a rotated left by bc bits.
- ROTQMBY: a shifted right by `by` bytes, zero fill. If by >= DATA_BYTES, the result is 0.
- SHUFB: control byte c = src_reg_c byte i.
  - If c[7:6]==10, the result byte is 0x00.
  - If c[7:5]==110, the result byte is 0xFF.
  - If c[7:5]==111, the result byte is 0x80.
  - Otherwise the result byte is byte (c mod 2*DATA_BYTES) of {a,b}.
- NOP, or any cycle with branch_is_taken=1: stage 0 is loaded with valid=0, addr=0, data=0.
- Undefined op encoding: treated as NOP, and illegal_op pulses the next cycle.
- enable_reg_write=0 with a legal op: the result is computed and travels the pipe with valid=0.

## Timing
- Stage k output register advances to stage k+1 on each unstalled edge.
- Writeback outputs are combinationally stage LATENCY-1. An instruction accepted at edge n appears on wb_* after edge n+LATENCY-1.
- fwd_*[k] exposes stage k. Stage 0 is valid from the edge after issue.
- stall=1: all stages, including stage 0, hold their values. Inputs, including branch_is_taken, are ignored. illegal_op is 0.
- stall and branch_is_taken in the same cycle: stall wins.
- Back-to-back issue is allowed every unstalled cycle; throughput is 1/cycle.
- Reset asserted, including mid-operation: all stage valid/addr/data and illegal_op go to 0 immediately. In-flight instructions are discarded.
- First acceptance is on the first rising edge after reset deasserts.

## Structure
- permute_pkg holds:
  - op_t enum: OP_NOP, OP_SHLQBI, OP_SHLQBY, OP_ROTQBY, OP_ROTQBI, OP_ROTQMBY, OP_SHUFB.
  - SHUFB special-code constants.
  - Amount-field bit positions.
- Sub-module permute_core: purely combinational (op, a, b, c, amt) -> result, illegal. permute_pipe instantiates it and owns the staging registers, stall and flush.

## Test plan
- Reset/pipe: a=0x00010203…0F, ROTQBY imm amt=3, enable=1, dest=5 → after LATENCY cycles wb_data=0x030405…0F000102, wb_reg_addr=5, wb_enable=1. All outputs 0 during reset.
- Shift bounds: SHLQBY amt=16 → 0. SHLQBI amt=0x0B (bc=3) on a=…0001 → …0008. ROTQMBY amt=1 → 0x00 prepended, last byte dropped.
- SHUFB: c bytes 0x80,0xC0,0xE0,0x1F, rest 0x00 → result bytes 0x00,0xFF,0x80, b byte 15, then a byte 0 repeated.
- Flush/stall:
  - Issue three ops, branch_is_taken on the second → its wb_enable=0 and addr=0; the other two are unaffected.
  - stall for 2 cycles mid-stream → all fwd taps frozen, wb delayed exactly 2 cycles.
- Illegal and async reset:
  - Undefined op → illegal_op=1 for one cycle and a NOP bubble.
  - Assert reset between edges with the pipe full → wb_enable drops before the next edge. No stale writeback after release.
